pattern_gen_stream: RTL

Parametrised successor of the fixed 12-bit pattern generator. It generates test frames of PIX_PER_LINE x LINES_PER_FRAME pixels, each DATA_W bits wide, and drives them onto a valid/ready stream with backpressure. Frame and line timing come from the f_sync and sync strobes. Supported patterns are ramp, constant, all-ones, binary counter and checkerboard, each with optional Gray coding. The block sits in the test-pattern path and replaces the fixed 12-bit counter tree.

---
 rtl/pattern_gen_stream_if.sv | 15 +
 rtl/pattern_gen_stream.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pattern_gen_stream_if.sv
// Pixel stream interface for pattern_gen_stream.
// Valid/ready: a beat transfers on a clk edge where out_valid && out_ready; while
// out_valid is high and out_ready low, out_data, line_end and frame_end hold stable.
interface pattern_gen_stream_if #(
  parameter int DATA_W = 12
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              line_end;
  logic              frame_end;

  modport master (output out_valid, out_data, line_end, frame_end, input out_ready);
  modport slave  (input out_valid, out_data, line_end, frame_end, output out_ready);
endinterface

// File: rtl/pattern_gen_stream.sv
// Parametrised test-pattern generator driving a valid/ready pixel stream.
// Optional PRBS pattern on mode 5 when PATGEN_PRBS_EN is defined.
module pattern_gen_stream #(
  parameter int DATA_W          = 12,
  parameter int PIX_PER_LINE    = 4096,
  parameter int LINES_PER_FRAME = 32,
  parameter int STEP_W          = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                f_sync,
  input  logic                sync,
  input  logic [DATA_W-1:0]   const_val,
  input  logic [STEP_W-1:0]   x_step,
  input  logic [STEP_W-1:0]   y_step,
  input  logic [2:0]          mode,
  input  logic                gray_en,
  pattern_gen_stream_if.master st,
  output logic                busy,
  output logic [1:0]          state_dbg
);
  localparam int CW = (PIX_PER_LINE > 1) ? $clog2(PIX_PER_LINE) : 1;
  localparam int LW = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, LINE = 2'd2, GAP = 2'd3} state_t;
  state_t state;

  logic [CW-1:0]     col;
  logic [LW-1:0]     line_idx;
  logic [DATA_W-1:0] row_base, ramp_cur, cnt_cur;
  logic [2:0]        mode_l;
  logic              gray_l;
  logic [STEP_W-1:0] x_step_l, y_step_l;
  logic [DATA_W-1:0] const_l;

`ifdef PATGEN_PRBS_EN
  localparam logic [15:0] PRBS_SEED = 16'hACE1;
  logic [15:0] lfsr, sel_lfsr;

  // Fibonacci x^16+x^14+x^13+x^11+1, shifting right.
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction
`endif

  logic              accept, start_line, last_col, last_line;
  logic [CW-1:0]     col_nxt;
  logic [2:0]        sel_mode;
  logic              sel_gray, sel_col0, sel_line0;
  logic [DATA_W-1:0] sel_const, sel_ramp, sel_cnt, pix, enc;

  assign accept     = st.out_valid && st.out_ready;
  assign start_line = sync && (f_sync || state == ARMED || state == GAP);
  assign last_col   = (col == CW'(PIX_PER_LINE - 1));
  assign last_line  = (line_idx == LW'(LINES_PER_FRAME - 1));
  assign col_nxt    = col + CW'(1);
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

  // Generator inputs for the next beat: either the first pixel of a new line or the successor of the current one.
  always_comb begin
    sel_mode  = mode_l;
    sel_gray  = gray_l;
    sel_const = const_l;
    sel_col0  = col_nxt[0];
    sel_line0 = line_idx[0];
    sel_ramp  = ramp_cur + DATA_W'(x_step_l);
    sel_cnt   = cnt_cur + DATA_W'(1);
`ifdef PATGEN_PRBS_EN
    sel_lfsr  = lfsr_step(lfsr);
`endif
    if (start_line) begin
      sel_mode  = mode;
      sel_gray  = gray_en;
      sel_const = const_val;
      sel_col0  = 1'b0;
      sel_line0 = f_sync ? 1'b0 : line_idx[0];
      sel_ramp  = f_sync ? '0 : row_base;
      sel_cnt   = (f_sync || line_idx == '0) ? const_val : cnt_cur;
`ifdef PATGEN_PRBS_EN
      sel_lfsr  = f_sync ? PRBS_SEED : lfsr;
`endif
    end
  end

  always_comb begin
    pix = '0;
    case (sel_mode)
      3'd0:    pix = sel_ramp;
      3'd1:    pix = sel_const;
      3'd2:    pix = '1;
      3'd3:    pix = sel_cnt;
      3'd4:    pix = {DATA_W{sel_col0 ^ sel_line0}};
`ifdef PATGEN_PRBS_EN
      3'd5:    pix = sel_lfsr[DATA_W-1:0];
`endif
      default: pix = '0;
    endcase
    enc = sel_gray ? (pix ^ (pix >> 1)) : pix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      st.out_valid <= 1'b0;
      st.out_data  <= '0;
      st.line_end  <= 1'b0;
      st.frame_end <= 1'b0;
      col          <= '0;
      line_idx     <= '0;
      row_base     <= '0;
      ramp_cur     <= '0;
      cnt_cur      <= '0;
      mode_l       <= '0;
      gray_l       <= 1'b0;
      x_step_l     <= '0;
      y_step_l     <= '0;
      const_l      <= '0;
`ifdef PATGEN_PRBS_EN
      lfsr         <= '0;
`endif
    end else begin
      if (f_sync) begin
        state        <= ARMED;
        st.out_valid <= 1'b0;
        st.line_end  <= 1'b0;
        st.frame_end <= 1'b0;
        col          <= '0;
        line_idx     <= '0;
        row_base     <= '0;
        cnt_cur      <= const_val;
`ifdef PATGEN_PRBS_EN
        lfsr         <= PRBS_SEED;
`endif
      end else if (state == LINE && accept) begin
        cnt_cur <= sel_cnt;
`ifdef PATGEN_PRBS_EN
        lfsr    <= sel_lfsr;
`endif
        if (last_col) begin
          st.out_valid <= 1'b0;
          st.line_end  <= 1'b0;
          st.frame_end <= 1'b0;
          col          <= '0;
          row_base     <= row_base + DATA_W'(y_step_l);
          if (last_line) begin
            state    <= IDLE;
            line_idx <= '0;
          end else begin
            state    <= GAP;
            line_idx <= line_idx + LW'(1);
          end
        end else begin
          col          <= col_nxt;
          ramp_cur     <= sel_ramp;
          st.out_data  <= enc;
          st.line_end  <= (col_nxt == CW'(PIX_PER_LINE - 1));
          st.frame_end <= (col_nxt == CW'(PIX_PER_LINE - 1)) && last_line;
        end
      end

      // Line start overrides the re-arm above when f_sync and sync coincide.
      if (start_line) begin
        state        <= LINE;
        st.out_valid <= 1'b1;
        st.out_data  <= enc;
        st.line_end  <= 1'b0;
        st.frame_end <= 1'b0;
        col          <= '0;
        mode_l       <= mode;
        gray_l       <= gray_en;
        x_step_l     <= x_step;
        y_step_l     <= y_step;
        const_l      <= const_val;
        ramp_cur     <= sel_ramp;
        cnt_cur      <= sel_cnt;
`ifdef PATGEN_PRBS_EN
        lfsr         <= sel_lfsr;
`endif
      end
    end
  end
endmodule
